// File: rtl/pkt_capture_pkg.sv
// Shared types and constants for the packet capture sequencer.
// PKT_CAPTURE_CTRL_CHKSUM_EN adds the trailer state used for the XOR checksum beat.
package pkt_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_SNAP  = 3'd2,
        ST_SEND  = 3'd3
`ifdef PKT_CAPTURE_CTRL_CHKSUM_EN
        , ST_TRAIL = 3'd4
`endif
    } state_t;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    localparam logic [1:0] SRC_ADC   = 2'd0;
    localparam logic [1:0] SRC_PAT24 = 2'd1;
    localparam logic [1:0] SRC_PAT48 = 2'd2;

    // Header layout: magic[35:32], src[31:30], pad[29:16], frames[15:0]
    localparam int HDR_W       = 36;
    localparam int HDR_PAD_W   = 14;
    localparam int HDR_FRM_W   = 16;

    function automatic logic [HDR_W-1:0] make_header(input logic [1:0] src,
                                                     input logic [HDR_FRM_W-1:0] frames);
        return {HDR_MAGIC, src, {HDR_PAD_W{1'b0}}, frames};
    endfunction

endpackage

// File: rtl/pkt_lane_sel.sv
// Source mux, per-frame snapshot register and lane word select.
module pkt_lane_sel
    import pkt_capture_pkg::*;
#(
    parameter int NUM_LANES = 24,
    parameter int DW        = 36,
    parameter int IDX_W     = $clog2(NUM_LANES)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      snap_en,
    input  logic [1:0]                src,
    input  logic [NUM_LANES*DW-1:0]   adc_data,
    input  logic [NUM_LANES*DW-1:0]   pat_data,
    input  logic [NUM_LANES/2*DW-1:0] pat48_data,
    input  logic [IDX_W-1:0]          idx,
    output logic [DW-1:0]             word
);

    logic [NUM_LANES*DW-1:0] src_bus;
    logic [NUM_LANES*DW-1:0] snap_q;

    // The half-width pattern leaves the upper snapshot lanes at zero.
    always_comb begin
        src_bus = adc_data;
        case (src)
            SRC_PAT24: src_bus = pat_data;
            SRC_PAT48: src_bus = {{((NUM_LANES - NUM_LANES/2)*DW){1'b0}}, pat48_data};
            default:   src_bus = adc_data;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        snap_q <= '0;
        else if (snap_en) snap_q <= src_bus;
    end

    assign word = snap_q[idx*DW +: DW];

endmodule

// File: rtl/pkt_capture_ctrl.sv
// Capture sequencer: header, per-frame snapshot, lane-serial stream, done/abort status.
// Define PKT_CAPTURE_CTRL_CHKSUM_EN to append an XOR checksum trailer beat.
module pkt_capture_ctrl
    import pkt_capture_pkg::*;
#(
    parameter int NUM_LANES = 24,
    parameter int DW        = 36,
    parameter int FRM_W     = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cfg_start,
    input  logic                      cfg_abort,
    input  logic [1:0]                cfg_src_sel,
    input  logic [FRM_W-1:0]          cfg_frames,
    input  logic [NUM_LANES*DW-1:0]   adc_data,
    input  logic [NUM_LANES*DW-1:0]   pat_data,
    input  logic [NUM_LANES/2*DW-1:0] pat48_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output state_t                    dbg_state
);

    localparam int IDX_W = $clog2(NUM_LANES);
    localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(NUM_LANES - 1);
    localparam logic [IDX_W-1:0] LAST_HALF = IDX_W'(NUM_LANES/2 - 1);

    state_t             state_q, state_d;
    logic [1:0]         src_q, src_d;
    logic [FRM_W-1:0]   frames_q, frames_d, frame_cnt_q, frame_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d, aborted_q, aborted_d;
    logic               snap_en, xfer, last_lane, last_frame;
    logic [DW-1:0]      lane_word;

    // Stream: a beat moves when out_valid & out_ready; out_valid comes only from state,
    // so data/sop/eop hold while stalled and valid drops only after a transfer or abort.
    assign xfer       = out_valid & out_ready;
    assign last_lane  = (idx_q == ((src_q == SRC_PAT48) ? LAST_HALF : LAST_FULL));
    assign last_frame = (frame_cnt_q == frames_q - FRM_W'(1));

    pkt_lane_sel #(.NUM_LANES(NUM_LANES), .DW(DW), .IDX_W(IDX_W)) u_lane_sel (
        .clk       (clk),
        .rstn      (rstn),
        .snap_en   (snap_en),
        .src       (src_q),
        .adc_data  (adc_data),
        .pat_data  (pat_data),
        .pat48_data(pat48_data),
        .idx       (idx_q),
        .word      (lane_word)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        frames_d    = frames_q;
        frame_cnt_d = frame_cnt_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        snap_en     = 1'b0;
        case (state_q)
            ST_IDLE: if (cfg_start) begin
                src_d       = (cfg_src_sel == 2'd3) ? SRC_ADC : cfg_src_sel;
                frames_d    = cfg_frames;
                frame_cnt_d = '0;
                idx_d       = '0;
                aborted_d   = 1'b0;
                if (cfg_frames == '0) done_d  = 1'b1;
                else                  state_d = ST_HDR;
            end
            ST_HDR:  if (xfer) state_d = ST_SNAP;
            ST_SNAP: begin
                snap_en = 1'b1;
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: if (xfer) begin
                if (!last_lane) begin
                    idx_d = idx_q + IDX_W'(1);
                end else if (!last_frame) begin
                    frame_cnt_d = frame_cnt_q + FRM_W'(1);
                    state_d     = ST_SNAP;
                end else begin
`ifdef PKT_CAPTURE_CTRL_CHKSUM_EN
                    state_d = ST_TRAIL;
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef PKT_CAPTURE_CTRL_CHKSUM_EN
            ST_TRAIL: if (xfer) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over any transfer completing in the same cycle.
        if (cfg_abort && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            frames_q    <= '0;
            frame_cnt_q <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            frames_q    <= frames_d;
            frame_cnt_q <= frame_cnt_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

`ifdef PKT_CAPTURE_CTRL_CHKSUM_EN
    logic [DW-1:0] chk_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                               chk_q <= '0;
        else if (state_q == ST_IDLE && cfg_start) chk_q <= '0;
        else if (state_q == ST_SEND && xfer)     chk_q <= chk_q ^ lane_word;
    end

    assign out_eop = (state_q == ST_TRAIL);
`else
    assign out_eop = (state_q == ST_SEND) && last_lane && last_frame;
`endif

    always_comb begin
        out_data = '0;
        case (state_q)
            ST_HDR:   out_data = DW'(make_header(src_q, HDR_FRM_W'(frames_q)));
            ST_SEND:  out_data = lane_word;
`ifdef PKT_CAPTURE_CTRL_CHKSUM_EN
            ST_TRAIL: out_data = chk_q;
`endif
            default:  out_data = '0;
        endcase
    end

`ifdef PKT_CAPTURE_CTRL_CHKSUM_EN
    assign out_valid = (state_q == ST_HDR) || (state_q == ST_SEND) || (state_q == ST_TRAIL);
`else
    assign out_valid = (state_q == ST_HDR) || (state_q == ST_SEND);
`endif
    assign out_sop   = (state_q == ST_HDR);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign dbg_state = state_q;

endmodule
